mmio_mailbox: RTL and testbench

MMIO_MAILBOX -- requirements
Module: mmio_mailbox

---
 rtl/mmio_mailbox_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/mmio_mailbox.sv | 143 ++++++++++++++
 tb/tb_mmio_mailbox.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_mailbox_pkg.sv
// Shared register map for the MMIO mailbox: register indices, STATUS layout, CTRL bits.
package mmio_mailbox_pkg;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;

    localparam int unsigned STS_TX_COUNT_LSB = 0;
    localparam int unsigned STS_RX_COUNT_LSB = 4;
    localparam int unsigned STS_TX_FULL      = 8;
    localparam int unsigned STS_RX_EMPTY     = 9;
    localparam int unsigned STS_ACC_BUSY     = 10;
    localparam int unsigned STS_DONE         = 11;
    localparam int unsigned STS_OVF_LSB      = 16;
    localparam int unsigned STS_UDF_LSB      = 24;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_FLUSH = 1;
    localparam int unsigned CTRL_CLEAR = 2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head, synchronous flush and occupancy count.
// A push while full is still taken when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned D_WIDTH = 64,
    parameter int unsigned DEPTH   = 8,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [D_WIDTH-1:0] wdata,
    output logic [D_WIDTH-1:0] rdata,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        count
);

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and count update; flush discards everything ahead of any push/pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (!do_push && do_pop)
                count <= count - (AW+1)'(1);
        end
    end

    // Storage write; the array is not reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mmio_mailbox.sv
// MMIO mailbox between the CPU MEM stage and an accelerator: TX/RX FIFOs,
// STATUS/CTRL registers, sticky done flag and saturating error counters.
module mmio_mailbox
    import mmio_mailbox_pkg::*;
#(
    parameter int unsigned D_WIDTH = 64,
    parameter int unsigned DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         mem_addr,
    input  logic [D_WIDTH-1:0] mem_wdata,
    input  logic               mem_we,
    input  logic               mem_re,
    output logic [D_WIDTH-1:0] mem_rdata,
    output logic [D_WIDTH-1:0] tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [D_WIDTH-1:0] rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               acc_start,
    input  logic               acc_busy,
    input  logic               acc_done
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic               in_region;
    logic [2:0]         reg_idx;
    logic               tx_store;
    logic               rx_load;
    logic               ctrl_wr;
    logic               flush;
    logic               tx_full;
    logic               tx_empty;
    logic               rx_full;
    logic               rx_empty;
    logic [AW:0]        tx_count;
    logic [AW:0]        rx_count;
    logic [D_WIDTH-1:0] rx_head;
    logic [D_WIDTH-1:0] status;
    logic [D_WIDTH-1:0] rd_next;
    logic               done_sticky;
    logic [7:0]         ovf_cnt;
    logic [7:0]         udf_cnt;
    logic               unused_addr;

    assign in_region = (mem_addr[9:8] != 2'b00);
    assign reg_idx   = mem_addr[5:3];
    assign tx_store  = mem_we && in_region && (reg_idx == REG_TXDATA);
    assign rx_load   = mem_re && in_region && (reg_idx == REG_RXDATA);
    assign ctrl_wr   = mem_we && in_region && (reg_idx == REG_CTRL);
    assign flush     = ctrl_wr && mem_wdata[CTRL_FLUSH];
    assign tx_valid  = !tx_empty;
    assign rx_ready  = !rx_full;
    assign unused_addr = ^{mem_addr[7:6], mem_addr[2:0]};

    // TX store while full is dropped on the current count, even if a pop frees a slot.
    sync_fifo #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_store && !tx_full),
        .pop   (tx_ready),
        .flush (flush),
        .wdata (mem_wdata),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // RX keeps its count at DEPTH when a CPU pop and an arriving word coincide.
    sync_fifo #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid),
        .pop   (rx_load),
        .flush (flush),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // STATUS word assembled from live FIFO state and sticky flags.
    always_comb begin
        status = '0;
        status[STS_TX_COUNT_LSB +: 4] = 4'(tx_count);
        status[STS_RX_COUNT_LSB +: 4] = 4'(rx_count);
        status[STS_TX_FULL]           = tx_full;
        status[STS_RX_EMPTY]          = rx_empty;
        status[STS_ACC_BUSY]          = acc_busy;
        status[STS_DONE]              = done_sticky;
        status[STS_OVF_LSB +: 8]      = ovf_cnt;
        status[STS_UDF_LSB +: 8]      = udf_cnt;
    end

    // Load data mux; unmapped, write-only and out-of-region reads yield zero.
    always_comb begin
        rd_next = '0;
        if (in_region) begin
            case (reg_idx)
                REG_RXDATA: rd_next = rx_empty ? '0 : rx_head;
                REG_STATUS: rd_next = status;
                default:    rd_next = '0;
            endcase
        end
    end

    // Registered load data, updated only on a load strobe.
    always_ff @(posedge clk) begin
        if (reset)
            mem_rdata <= '0;
        else if (mem_re)
            mem_rdata <= rd_next;
    end

    // Start pulse, sticky done (set beats clear) and saturating error counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_start   <= 1'b0;
            done_sticky <= 1'b0;
            ovf_cnt     <= '0;
            udf_cnt     <= '0;
        end else begin
            acc_start <= ctrl_wr && mem_wdata[CTRL_START];
            if (acc_done)
                done_sticky <= 1'b1;
            else if (ctrl_wr && mem_wdata[CTRL_CLEAR])
                done_sticky <= 1'b0;
            if (ctrl_wr && mem_wdata[CTRL_CLEAR]) begin
                ovf_cnt <= '0;
                udf_cnt <= '0;
            end else begin
                if (tx_store && tx_full) ovf_cnt <= sat_inc8(ovf_cnt);
                if (rx_load && rx_empty) udf_cnt <= sat_inc8(udf_cnt);
            end
        end
    end

endmodule

// File: tb/tb_mmio_mailbox.sv
// Self-checking bench for mmio_mailbox: directed scenarios plus random traffic
// compared against a queue-based model of the mailbox.
module tb_mmio_mailbox;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [63:0] mem_rdata;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        acc_start;
    logic        acc_busy;
    logic        acc_done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] tx_q[$];
    logic [63:0] rx_q[$];
    int          m_ovf;
    int          m_udf;
    logic        m_done;
    logic [63:0] m_rdata;

    mmio_mailbox #(.D_WIDTH(64), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .acc_start (acc_start),
        .acc_busy  (acc_busy),
        .acc_done  (acc_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_status();
        logic [63:0] s;
        s = '0;
        s[3:0]   = 4'(tx_q.size());
        s[7:4]   = 4'(rx_q.size());
        s[8]     = (tx_q.size() == 8);
        s[9]     = (rx_q.size() == 0);
        s[10]    = acc_busy;
        s[11]    = m_done;
        s[23:16] = 8'(m_ovf);
        s[31:24] = 8'(m_udf);
        return s;
    endfunction

    task automatic idle_inputs();
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        rx_valid = 1'b0;
        acc_done = 1'b0;
        tx_ready = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; advances one cycle.
    task automatic step();
        logic        in_r;
        logic [2:0]  idx;
        logic        rx_pop, rx_push, tx_pop, tx_push, exp_start;
        logic [63:0] st;
        check("tx_valid", tx_valid, tx_q.size() != 0);
        if (tx_q.size() > 0) check("tx_data", tx_data, tx_q[0]);
        check("rx_ready", rx_ready, rx_q.size() < 8);
        in_r = (mem_addr[9:8] != 2'b00);
        idx  = mem_addr[5:3];
        st   = model_status();
        rx_pop = mem_re && in_r && idx == 3'd1 && rx_q.size() > 0;
        if (mem_re) begin
            m_rdata = '0;
            if (in_r && idx == 3'd1) begin
                if (rx_q.size() == 0) begin
                    if (m_udf < 255) m_udf++;
                end else m_rdata = rx_q[0];
            end else if (in_r && idx == 3'd2) m_rdata = st;
        end
        rx_push = rx_valid && (rx_q.size() < 8 || rx_pop);
        tx_pop  = tx_ready && tx_q.size() > 0;
        tx_push = 1'b0;
        if (mem_we && in_r && idx == 3'd0) begin
            if (tx_q.size() == 8) begin
                if (m_ovf < 255) m_ovf++;
            end else tx_push = 1'b1;
        end
        if (tx_pop)  void'(tx_q.pop_front());
        if (tx_push) tx_q.push_back(mem_wdata);
        if (rx_pop)  void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(rx_data);
        exp_start = 1'b0;
        if (mem_we && in_r && idx == 3'd3) begin
            exp_start = mem_wdata[0];
            if (mem_wdata[1]) begin
                tx_q.delete();
                rx_q.delete();
            end
            if (mem_wdata[2]) begin
                m_ovf = 0;
                m_udf = 0;
                m_done = 1'b0;
            end
        end
        if (acc_done) m_done = 1'b1;
        @(negedge clk);
        check("mem_rdata", mem_rdata, m_rdata);
        check("acc_start", acc_start, exp_start);
        idle_inputs();
    endtask

    task automatic st_op(input logic [9:0] a, input logic [63:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        step();
    endtask

    task automatic ld_op(input logic [9:0] a);
        mem_addr = a;
        mem_re   = 1'b1;
        step();
    endtask

    task automatic do_reset();
        idle_inputs();
        mem_addr  = '0;
        mem_wdata = '0;
        rx_data   = '0;
        acc_busy  = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tx_q.delete();
        rx_q.delete();
        m_ovf   = 0;
        m_udf   = 0;
        m_done  = 1'b0;
        m_rdata = '0;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_mem_rdata", mem_rdata, 64'd0);
        check("rst_acc_start", acc_start, 1'b0);
    endtask

    initial begin
        logic [63:0] s;
        logic [9:0]  a;
        int          op;
        @(negedge clk);

        // TX push of three words then drain with tx_ready held high.
        do_reset();
        st_op(10'h100, 64'hA);
        st_op(10'h100, 64'hB);
        st_op(10'h100, 64'hC);
        check("tx_head_A", tx_data, 64'hA);
        for (int i = 0; i < 3; i++) begin
            tx_ready = 1'b1;
            step();
        end
        check("tx_drained", tx_valid, 1'b0);
        ld_op(10'h110);
        s = mem_rdata;
        check("tx_count_zero", s[3:0], 64'd0);

        // Nine stores with the accelerator stalled: one dropped.
        do_reset();
        for (int i = 0; i < 9; i++) st_op(10'h100, 64'(i + 16));
        ld_op(10'h110);
        s = mem_rdata;
        check("tx_count_8", s[3:0], 64'd8);
        check("tx_full", s[8], 1'b1);
        check("ovf_1", s[23:16], 64'd1);

        // Single RX word, then an underflowing load.
        do_reset();
        rx_valid = 1'b1;
        rx_data  = 64'h55;
        step();
        ld_op(10'h108);
        check("rx_55", mem_rdata, 64'h55);
        ld_op(10'h108);
        check("rx_udf_data", mem_rdata, 64'd0);
        ld_op(10'h110);
        s = mem_rdata;
        check("udf_1", s[31:24], 64'd1);

        // Full RX with simultaneous CPU pop and arriving word.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_data  = 64'(i + 1);
            step();
        end
        check("rx_full_ready", rx_ready, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 64'h99;
        ld_op(10'h108);
        check("rx_pop_first", mem_rdata, 64'd1);
        check("rx_ready_stays0", rx_ready, 1'b0);
        ld_op(10'h110);
        s = mem_rdata;
        check("rx_count_8", s[7:4], 64'd8);
        for (int i = 0; i < 8; i++) begin
            ld_op(10'h108);
            check("rx_order", mem_rdata, (i == 7) ? 64'h99 : 64'(i + 2));
        end

        // Start plus flush with both FIFOs populated.
        do_reset();
        st_op(10'h100, 64'h1234);
        st_op(10'h100, 64'h5678);
        rx_valid = 1'b1;
        rx_data  = 64'h77;
        step();
        st_op(10'h118, 64'h3);
        check("start_pulse", acc_start, 1'b1);
        ld_op(10'h110);
        check("start_one_cycle", acc_start, 1'b0);
        s = mem_rdata;
        check("flush_counts", s[7:0], 64'd0);

        // done pulse coincident with a clear; unmapped loads read zero.
        do_reset();
        ld_op(10'h108);
        for (int i = 0; i < 9; i++) st_op(10'h100, 64'(i));
        mem_addr  = 10'h118;
        mem_wdata = 64'h4;
        mem_we    = 1'b1;
        acc_done  = 1'b1;
        step();
        ld_op(10'h110);
        s = mem_rdata;
        check("done_set", s[11], 1'b1);
        check("ovf_cleared", s[23:16], 64'd0);
        check("udf_cleared", s[31:24], 64'd0);
        ld_op(10'h000);
        check("ld_out_region", mem_rdata, 64'd0);
        ld_op(10'h110);
        ld_op(10'h138);
        check("ld_idx7", mem_rdata, 64'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = {$urandom, $urandom};
            acc_busy = 1'($urandom_range(0, 1));
            acc_done = ($urandom_range(0, 7) == 0);
            op = $urandom_range(0, 9);
            a  = {2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 3'd0, 3'($urandom_range(0, 7))};
            case (op)
                0, 1, 2: begin a[5:3] = 3'd0; mem_we = 1'b1; end
                3, 4:    begin a[5:3] = 3'd1; mem_re = 1'b1; end
                5:       begin a[5:3] = 3'd2; mem_re = 1'b1; end
                6:       if ($urandom_range(0, 3) == 0) begin a[5:3] = 3'd3; mem_we = 1'b1; end
                7:       begin a[5:3] = 3'($urandom_range(0, 7));
                               if ($urandom_range(0, 1) == 1) a[9:8] = 2'b00;
                               mem_re = 1'b1; end
                8:       begin a[9:8] = 2'b00; a[5:3] = 3'($urandom_range(0, 3)); mem_we = 1'b1; end
                default: ;
            endcase
            mem_addr  = a;
            mem_wdata = {$urandom, $urandom};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
